// File: rtl/mul_arbiter_if.sv
// Bundle of requester, multiplier and result signals shared between mul_arbiter
// and whatever drives it; the arbiter itself uses the slave view.
interface mul_arbiter_if #(
   parameter int N    = 8,
   parameter int NREQ = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic [N-1:0]      mul_a;
   logic [N-1:0]      mul_b;
   logic [2*N-1:0]    mul_p;
   logic              res_valid;
   logic              res_ready;
   logic [2*N-1:0]    res_p;
   logic [IDW-1:0]    res_id;
   logic              busy;

   modport slave (
      input  req_valid, req_a, req_b, mul_p, res_ready,
      output req_ready, mul_a, mul_b, res_valid, res_p, res_id, busy
   );

   modport master (
      output req_valid, req_a, req_b, mul_p, res_ready,
      input  req_ready, mul_a, mul_b, res_valid, res_p, res_id, busy
   );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one external combinational array multiplier
// between NREQ requesters, waiting SETTLE cycles for the product before presenting it.
module mul_arbiter #(
   parameter int N      = 8,
   parameter int NREQ   = 4,
   parameter int SETTLE = 2
) (
   input  logic        clk,
   input  logic        rst,
   mul_arbiter_if.slave bus
);
   localparam int IDW = $clog2(NREQ);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_SETTLE,
      ST_DONE
   } state_t;

   state_t         state;
   state_t         nxt;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] id;
   logic [IDW-1:0] win;
   logic           found;
   logic [3:0]     cnt;

   // Winner search: first valid requester at or above ptr, wrapping back to 0.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && bus.req_valid[(int'(ptr) + k) % NREQ]) begin
            found = 1'b1;
            win   = IDW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt           = state;
      bus.req_ready = '0;
      case (state)
         ST_IDLE: begin
            if (|bus.req_valid) nxt = ST_GRANT;
         end
         ST_GRANT: begin
            if (found) begin
               bus.req_ready[win] = 1'b1;
               nxt                = ST_SETTLE;
            end else begin
               nxt = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (cnt == '0) nxt = ST_DONE;
         end
         ST_DONE: begin
            if (bus.res_ready) nxt = (|bus.req_valid) ? ST_GRANT : ST_IDLE;
         end
         default: nxt = ST_IDLE;
      endcase
   end

   // Operands are frozen at grant, so the multiplier sees a stable input for the whole settle window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr           <= '0;
         id            <= '0;
         cnt           <= '0;
         bus.mul_a     <= '0;
         bus.mul_b     <= '0;
         bus.res_p     <= '0;
         bus.res_id    <= '0;
         bus.res_valid <= 1'b0;
      end else begin
         case (state)
            ST_GRANT: begin
               if (found) begin
                  bus.mul_a <= bus.req_a[int'(win)*N +: N];
                  bus.mul_b <= bus.req_b[int'(win)*N +: N];
                  id        <= win;
                  cnt       <= 4'(SETTLE - 1);
               end
            end
            ST_SETTLE: begin
               if (cnt == '0) begin
                  bus.res_p     <= bus.mul_p;
                  bus.res_id    <= id;
                  bus.res_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.res_ready) begin
                  bus.res_valid <= 1'b0;
                  ptr <= (bus.res_id == IDW'(NREQ - 1)) ? '0 : bus.res_id + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy = (state != ST_IDLE);
endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: a transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mul_arbiter;
   localparam int N      = 8;
   localparam int NREQ   = 4;
   localparam int SETTLE = 2;

   typedef enum {M_IDLE, M_GRANT, M_WORK} mphase_t;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   int   cycle = 0;

   mul_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

   mul_arbiter #(.N(N), .NREQ(NREQ), .SETTLE(SETTLE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Stand-in for the external array multiplier.
   assign bus.mul_p = {8'h00, bus.mul_a} * {8'h00, bus.mul_b};

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   mphase_t     mPhase = M_IDLE;
   int          mPtr = 0;
   int          doneAt = 0;
   int          expId = 0;
   logic [7:0]  expA = '0;
   logic [7:0]  expB = '0;
   logic [15:0] expP = '0;
   bit          mFound;
   int          mWin;
   bit          expValid;
   int          readyPulses = 0;
   int          riseCount = 0;
   int          lastGrantCycle = 0;
   int          lastRiseCycle = 0;
   logic        prevValid = 1'b0;
   int          hsIds[$];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Reference model: grants follow the cycle after a request is seen, results appear SETTLE+1 cycles after grant.
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("rst_req_ready", bus.req_ready, 0);
         checkOutput("rst_res_valid", bus.res_valid, 0);
         checkOutput("rst_busy", bus.busy, 0);
         checkOutput("rst_mul_a", bus.mul_a, 0);
         checkOutput("rst_mul_b", bus.mul_b, 0);
         checkOutput("rst_res_p", bus.res_p, 0);
         checkOutput("rst_res_id", bus.res_id, 0);
         mPhase = M_IDLE;
         mPtr   = 0;
      end else begin
         case (mPhase)
            M_IDLE: begin
               checkOutput("idle_req_ready", bus.req_ready, 0);
               checkOutput("idle_res_valid", bus.res_valid, 0);
               checkOutput("idle_busy", bus.busy, 0);
               if (|bus.req_valid) mPhase = M_GRANT;
            end
            M_GRANT: begin
               mFound = 1'b0;
               mWin   = 0;
               for (int k = 0; k < NREQ; k++) begin
                  if (!mFound && bus.req_valid[(mPtr + k) % NREQ]) begin
                     mFound = 1'b1;
                     mWin   = (mPtr + k) % NREQ;
                  end
               end
               checkOutput("grant_req_ready", bus.req_ready, mFound ? (64'd1 << mWin) : 64'd0);
               checkOutput("grant_busy", bus.busy, 1);
               checkOutput("grant_res_valid", bus.res_valid, 0);
               if (mFound) begin
                  expA   = bus.req_a[mWin*N +: N];
                  expB   = bus.req_b[mWin*N +: N];
                  expP   = 16'(expA) * 16'(expB);
                  expId  = mWin;
                  doneAt = cycle + SETTLE + 1;
                  mPhase = M_WORK;
               end else begin
                  mPhase = M_IDLE;
               end
            end
            default: begin
               expValid = (cycle >= doneAt);
               checkOutput("work_busy", bus.busy, 1);
               checkOutput("work_req_ready", bus.req_ready, 0);
               checkOutput("work_res_valid", bus.res_valid, expValid);
               checkOutput("work_mul_a", bus.mul_a, expA);
               checkOutput("work_mul_b", bus.mul_b, expB);
               if (expValid) begin
                  checkOutput("res_p", bus.res_p, expP);
                  checkOutput("res_id", bus.res_id, expId);
                  if (bus.res_ready) begin
                     mPtr   = (expId + 1) % NREQ;
                     mPhase = (|bus.req_valid) ? M_GRANT : M_IDLE;
                  end
               end
            end
         endcase
      end
      if (bus.req_ready != '0) begin
         readyPulses++;
         lastGrantCycle = cycle;
      end
      if (bus.res_valid && !prevValid) begin
         riseCount++;
         lastRiseCycle = cycle;
      end
      if (bus.res_valid && bus.res_ready && !rst) hsIds.push_back(int'(bus.res_id));
      prevValid = bus.res_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] rv, input logic [31:0] ra, input logic [31:0] rb, input logic rr);
      bus.req_valid = rv;
      bus.req_a     = ra;
      bus.req_b     = rb;
      bus.res_ready = rr;
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(4'h0, 32'h0, 32'h0, 1'b0);
      repeat (2) tick();
      rst = 1'b0;
   endtask

   // which: 0 waits for any req_ready, 1 waits for res_valid.
   task automatic waitFor(input string what, input int which);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = (which == 0) ? (bus.req_ready != '0) : bus.res_valid;
      end
      if (!seen) checkOutput({what, "_timeout"}, 0, 1);
   endtask

   task automatic serve(input string tag, input int idx, input logic [7:0] a, input logic [7:0] b,
                        input int holdCycles, input logic [15:0] wantP);
      logic [31:0] ra;
      logic [31:0] rb;
      int          pulses;
      ra = '0;
      rb = '0;
      ra[idx*8 +: 8] = a;
      rb[idx*8 +: 8] = b;
      applyStimulus(4'(1 << idx), ra, rb, 1'b0);
      waitFor({tag, "_grant"}, 0);
      tick();
      bus.req_valid = '0;
      pulses = readyPulses;
      waitFor({tag, "_result"}, 1);
      checkOutput({tag, "_res_p"}, bus.res_p, wantP);
      checkOutput({tag, "_res_id"}, bus.res_id, idx);
      repeat (holdCycles) tick();
      if (holdCycles > 0) begin
         checkOutput({tag, "_held_res_p"}, bus.res_p, wantP);
         checkOutput({tag, "_held_res_id"}, bus.res_id, idx);
         checkOutput({tag, "_held_res_valid"}, bus.res_valid, 1);
         checkOutput({tag, "_held_no_ready"}, readyPulses, pulses);
      end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
   endtask

   initial begin
      int pulses0;
      int rise0;
      int expSeq[6];
      expSeq = '{0, 1, 2, 3, 0, 1};
      rst = 1'b1;
      applyStimulus(4'h0, 32'h0, 32'h0, 1'b0);
      doReset();

      // Single requester and its latency from grant to result.
      pulses0 = readyPulses;
      serve("single", 0, 8'h0F, 8'h11, 0, 16'h00FF);
      checkOutput("single_latency", lastRiseCycle - lastGrantCycle, SETTLE + 1);
      checkOutput("single_ready_pulses", readyPulses - pulses0, 1);

      serve("backpressure", 1, 8'h12, 8'h34, 10, 16'h03A8);
      serve("max_operands", 3, 8'hFF, 8'hFF, 0, 16'hFE01);
      serve("zero_operand", 2, 8'h00, 8'hA5, 0, 16'h0000);
      serve("shift_operand", 1, 8'h80, 8'h02, 0, 16'h0100);

      // All requesters valid, consumer always ready.
      doReset();
      hsIds.delete();
      applyStimulus(4'hF, 32'h0403_0201, 32'h0807_0605, 1'b1);
      for (int i = 0; i < 80 && hsIds.size() < 6; i++) tick();
      if (hsIds.size() < 6) checkOutput("rr_timeout", hsIds.size(), 6);
      for (int i = 0; i < 6; i++)
         checkOutput($sformatf("rr_id%0d", i), (hsIds.size() > i) ? hsIds[i] : 99, expSeq[i]);
      applyStimulus(4'h0, 32'h0, 32'h0, 1'b1);
      repeat (8) tick();
      bus.res_ready = 1'b0;

      // Requester 2 withdraws just as the grant happens; 3 takes it.
      doReset();
      applyStimulus(4'b0100, 32'h0709_0000, 32'h0909_0000, 1'b0);
      tick();
      bus.req_valid = 4'b1000;
      tick();
      bus.req_valid = 4'b0000;
      waitFor("withdraw_result", 1);
      checkOutput("withdraw_res_id", bus.res_id, 3);
      checkOutput("withdraw_res_p", bus.res_p, 16'h003F);
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      rise0   = riseCount;
      pulses0 = readyPulses;
      bus.req_valid = 4'b0100;
      tick();
      bus.req_valid = 4'b0000;
      repeat (8) tick();
      checkOutput("withdraw_none_result", riseCount, rise0);
      checkOutput("withdraw_none_ready", readyPulses, pulses0);
      checkOutput("withdraw_none_busy", bus.busy, 0);

      // Reset pulsed while the multiplier is settling.
      rise0 = riseCount;
      applyStimulus(4'b0001, 32'h0000_0005, 32'h0000_0006, 1'b0);
      waitFor("midrst_grant", 0);
      tick();
      bus.req_valid = 4'b0000;
      #1 rst = 1'b1;
      #1;
      checkOutput("midrst_busy", bus.busy, 0);
      checkOutput("midrst_res_valid", bus.res_valid, 0);
      checkOutput("midrst_mul_a", bus.mul_a, 0);
      checkOutput("midrst_mul_b", bus.mul_b, 0);
      checkOutput("midrst_res_p", bus.res_p, 0);
      checkOutput("midrst_res_id", bus.res_id, 0);
      checkOutput("midrst_req_ready", bus.req_ready, 0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (8) tick();
      checkOutput("midrst_no_result", riseCount, rise0);
      checkOutput("midrst_idle", bus.busy, 0);

      // Randomized traffic, with occasional reset pulses.
      doReset();
      for (int i = 0; i < 600; i++) begin
         applyStimulus(4'($urandom), $urandom, $urandom, 1'($urandom_range(0, 1)));
         rst = ($urandom_range(0, 149) == 0);
         tick();
      end
      rst = 1'b0;
      applyStimulus(4'h0, 32'h0, 32'h0, 1'b1);
      repeat (10) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
